// File: rtl/spi_pkg.sv
// Shared constants for the parametrised SPI transmitter: FSM state encodings
// and the four SPI modes expressed as {CPOL, CPHA}.
package spi_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SETUP = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_HOLD  = 2'd3;

   localparam logic [1:0] SPI_MODE0 = 2'b00;
   localparam logic [1:0] SPI_MODE1 = 2'b01;
   localparam logic [1:0] SPI_MODE2 = 2'b10;
   localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage

// File: rtl/spi_tx_param.sv
// Word-wide SPI master transmitter with selectable mode and bit order, owning
// an active-low chip select that can be held low across a burst of words.
module spi_tx_param
   import spi_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter bit          CPOL      = 1'b0,
   parameter bit          CPHA      = 1'b0,
   parameter bit          LSB_FIRST = 1'b0
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clk_en,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] data_in,
   input  logic             cs_keep,
   output logic             ready,
   output logic             sent,
   output logic             serial_out,
   output logic             serial_clock,
   output logic             cs_n
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [1:0]  MODE = {CPOL, CPHA};
   // Modes 1 and 3 launch data on the leading edge; 0 and 2 pre-load it.
   localparam bit LEAD_DATA = (MODE == SPI_MODE1) || (MODE == SPI_MODE3);

   logic [1:0]       state;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shifted;
   logic [CW-1:0]    cnt;
   logic             keep;
   logic             phase;
   logic             cur_bit;
   logic             next_bit;
   logic             first_bit;

   assign ready = (state == ST_IDLE);

   always_comb begin
      if (LSB_FIRST) begin
         cur_bit   = shreg[0];
         next_bit  = shreg[1];
         shifted   = {1'b0, shreg[WIDTH-1:1]};
         first_bit = data_in[0];
      end else begin
         cur_bit   = shreg[WIDTH-1];
         next_bit  = shreg[WIDTH-2];
         shifted   = {shreg[WIDTH-2:0], 1'b0};
         first_bit = data_in[WIDTH-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         serial_out   <= 1'b0;
         serial_clock <= CPOL;
         cs_n         <= 1'b1;
         sent         <= 1'b0;
         cnt          <= '0;
         shreg        <= '0;
         keep         <= 1'b0;
         phase        <= 1'b0;
      end else begin
         sent <= 1'b0;
         case (state)
            ST_IDLE: begin
               serial_clock <= CPOL;
               if (wr_en) begin
                  shreg <= data_in;
                  keep  <= cs_keep;
                  cnt   <= CW'(WIDTH - 1);
                  phase <= 1'b0;
                  cs_n  <= 1'b0;
                  state <= ST_SETUP;
                  if (!LEAD_DATA) begin
                     serial_out <= first_bit;
                  end
               end
            end
            ST_SETUP: begin
               if (clk_en) begin
                  state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (clk_en) begin
                  if (!phase) begin
                     serial_clock <= ~CPOL;
                     phase        <= 1'b1;
                     if (LEAD_DATA) begin
                        serial_out <= cur_bit;
                     end
                  end else begin
                     serial_clock <= CPOL;
                     phase        <= 1'b0;
                     if (cnt != '0) begin
                        shreg <= shifted;
                        cnt   <= cnt - 1'b1;
                        if (!LEAD_DATA) begin
                           serial_out <= next_bit;
                        end
                     end else if (keep) begin
                        // Burst word: stay selected so the next word follows seamlessly.
                        sent  <= 1'b1;
                        state <= ST_IDLE;
                     end else begin
                        state <= ST_HOLD;
                     end
                  end
               end
            end
            ST_HOLD: begin
               if (clk_en) begin
                  cs_n  <= 1'b1;
                  sent  <= 1'b1;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_tx_param.sv
// Bench driving several spi_tx_param configurations side by side; a serial
// receiver model reconstructs each word and a queue holds the expected results.
module tb_spi_tx_param;
   import spi_pkg::*;

   localparam int NCH     = 11;
   localparam int REC_MAX = 16;
   localparam int         W_T    [NCH] = '{8, 8, 12, 2, 2, 2, 2, 32, 32, 32, 32};
   localparam logic [1:0] MODE_T [NCH] = '{SPI_MODE0, SPI_MODE3, SPI_MODE0,
                                           SPI_MODE0, SPI_MODE1, SPI_MODE2, SPI_MODE3,
                                           SPI_MODE0, SPI_MODE1, SPI_MODE2, SPI_MODE3};
   localparam bit         LSB_T  [NCH] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
                                           1'b1, 1'b0, 1'b0, 1'b1};

   typedef struct {
      int          ch;
      logic [31:0] word;
      int          trans;
      int          sent_cyc;
      logic        csn;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             ce_fast;
   logic             ce_slow;
   logic [NCH-1:0]   wr;
   logic [NCH-1:0]   kp;
   logic [31:0]      din [NCH];
   logic [NCH-1:0]   rdy, snt, so, sclk, csn;

   int               cyc;
   int               n_assert = 0;
   int               n_fail = 0;
   exp_t             exp_q[$];
   int               rd [NCH];

   logic [NCH-1:0]   psclk;
   logic [NCH-1:0]   csok;
   logic [31:0]      rx [NCH];
   int               trans [NCH];
   int               rec_n [NCH];
   logic [31:0]      rec_word [NCH][REC_MAX];
   int               rec_trans [NCH][REC_MAX];
   int               rec_cyc [NCH][REC_MAX];
   logic             rec_csn [NCH][REC_MAX];
   logic             rec_csok [NCH][REC_MAX];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < NCH; g++) begin : g_dut
      spi_tx_param #(
         .WIDTH     (W_T[g]),
         .CPOL      (MODE_T[g][1]),
         .CPHA      (MODE_T[g][0]),
         .LSB_FIRST (LSB_T[g])
      ) u_dut (
         .clk          (clk),
         .rst_n        (rst_n),
         .clk_en       ((g == 2) ? ce_slow : ce_fast),
         .wr_en        (wr[g]),
         .data_in      (din[g][W_T[g]-1:0]),
         .cs_keep      (kp[g]),
         .ready        (rdy[g]),
         .sent         (snt[g]),
         .serial_out   (so[g]),
         .serial_clock (sclk[g]),
         .cs_n         (csn[g])
      );
   end

   function automatic logic [31:0] wmask(input int w);
      if (w >= 32) return 32'hFFFF_FFFF;
      return (32'h1 << w) - 32'h1;
   endfunction

   // A slave samples on the leading edge in CPHA=0 modes and on the trailing edge otherwise.
   function automatic logic [31:0] rx_next(input int c);
      logic [31:0] r;
      logic        lead;
      r    = rx[c];
      lead = (sclk[c] != MODE_T[c][1]);
      if ((sclk[c] !== psclk[c]) && (lead ^ MODE_T[c][0])) begin
         r = LSB_T[c] ? {so[c], r[31:1]} : {r[30:0], so[c]};
      end
      return r;
   endfunction

   function automatic int trans_next(input int c);
      return trans[c] + ((sclk[c] !== psclk[c]) ? 1 : 0);
   endfunction

   function automatic logic csok_next(input int c);
      return csok[c] && !((sclk[c] !== psclk[c]) && csn[c]);
   endfunction

   function automatic logic [31:0] extract(input int c, input logic [31:0] r);
      if (LSB_T[c]) return r >> (32 - W_T[c]);
      return r & wmask(W_T[c]);
   endfunction

   // Receiver model: watches every channel and logs one record per sent pulse.
   always @(negedge clk) begin
      for (int c = 0; c < NCH; c++) begin
         if (!rst_n) begin
            rx[c]    <= '0;
            trans[c] <= 0;
            csok[c]  <= 1'b1;
            psclk[c] <= sclk[c];
         end else begin
            psclk[c] <= sclk[c];
            if (snt[c]) begin
               if (rec_n[c] < REC_MAX) begin
                  rec_word[c][rec_n[c]]  <= extract(c, rx_next(c));
                  rec_trans[c][rec_n[c]] <= trans_next(c);
                  rec_cyc[c][rec_n[c]]   <= cyc;
                  rec_csn[c][rec_n[c]]   <= csn[c];
                  rec_csok[c][rec_n[c]]  <= csok_next(c);
               end
               rec_n[c] <= rec_n[c] + 1;
               rx[c]    <= '0;
               trans[c] <= 0;
               csok[c]  <= 1'b1;
            end else begin
               rx[c]    <= rx_next(c);
               trans[c] <= trans_next(c);
               csok[c]  <= csok_next(c);
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Issues one word on channel c from a negedge and returns one negedge after acceptance.
   task automatic applyStimulus(input int c, input logic [31:0] data, input logic keep,
                                input bit expect_done);
      exp_t e;
      int   k;
      k = 0;
      while (!rdy[c] && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (!rdy[c]) check($sformatf("ch%0d_ready_timeout", c), rdy[c], 1);
      din[c] = data;
      kp[c]  = keep;
      wr[c]  = 1'b1;
      e.ch       = c;
      e.word     = data & wmask(W_T[c]);
      e.trans    = 2 * W_T[c];
      e.csn      = !keep;
      e.sent_cyc = (c == 2) ? -1 : cyc + 1 + 2 * W_T[c] + (keep ? 1 : 2);
      if (expect_done) exp_q.push_back(e);
      @(negedge clk);
      wr[c]  = 1'b0;
      din[c] = ~data;
      kp[c]  = ~keep;
   endtask

   task automatic checkOutput(input int budget);
      exp_t e;
      int   c;
      int   k;
      e = exp_q.pop_front();
      c = e.ch;
      k = 0;
      while (rec_n[c] <= rd[c] && k < budget) begin
         @(negedge clk);
         k++;
      end
      check($sformatf("ch%0d_sent_count", c), rec_n[c], rd[c] + 1);
      if (rec_n[c] > rd[c]) begin
         check($sformatf("ch%0d_word", c), rec_word[c][rd[c]], e.word);
         check($sformatf("ch%0d_transitions", c), rec_trans[c][rd[c]], e.trans);
         check($sformatf("ch%0d_csn_at_sent", c), rec_csn[c][rd[c]], e.csn);
         check($sformatf("ch%0d_cs_low_while_clocking", c), rec_csok[c][rd[c]], 1);
         if (e.sent_cyc >= 0) check($sformatf("ch%0d_sent_latency", c), rec_cyc[c][rd[c]], e.sent_cyc);
         rd[c]++;
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int   k;
      int   n_cs_high;
      int   rises;
      int   bad_period;
      int   last_rise;
      logic prev;

      rst_n   = 1'b0;
      ce_fast = 1'b1;
      ce_slow = 1'b0;
      wr      = '0;
      kp      = '0;
      for (int c = 0; c < NCH; c++) din[c] = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] reset in the middle of a word");
      applyStimulus(0, 32'hFF, 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      check("midword_csn", csn[0], 0);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      check("rst_csn", csn[0], 1);
      check("rst_sclk", sclk[0], 0);
      check("rst_sent", snt[0], 0);
      check("rst_ready", rdy[0], 1);
      check("rst_serial_out", so[0], 0);
      check("rst_sclk_cpol1", sclk[1], 1);
      repeat (30) @(negedge clk);
      check("rst_no_sent_after_abort", rec_n[0], 0);

      $display("[TB] mode 0 MSB first 0xA5");
      applyStimulus(0, 32'hA5, 1'b0, 1'b1);
      checkOutput(40);
      repeat (3) @(negedge clk);
      check("a5_single_pulse", rec_n[0], rd[0]);

      $display("[TB] mode 3 LSB first 0xA5");
      applyStimulus(1, 32'hA5, 1'b0, 1'b1);
      checkOutput(40);
      repeat (3) @(negedge clk);
      check("m3_idle_high", sclk[1], 1);
      check("m3_single_pulse", rec_n[1], rd[1]);

      $display("[TB] burst 0x3C keep then 0xC3");
      applyStimulus(0, 32'h3C, 1'b1, 1'b1);
      n_cs_high = 0;
      k = 0;
      while (!snt[0] && k < 100) begin
         if (csn[0]) n_cs_high++;
         @(negedge clk);
         k++;
      end
      applyStimulus(0, 32'hC3, 1'b0, 1'b1);
      while (!snt[0] && k < 200) begin
         if (csn[0]) n_cs_high++;
         @(negedge clk);
         k++;
      end
      check("burst_cs_high_cycles", n_cs_high, 0);
      checkOutput(10);
      checkOutput(10);
      repeat (3) @(negedge clk);
      check("burst_pulse_count", rec_n[0], rd[0]);

      $display("[TB] slow tick, 12-bit word 0xABC");
      applyStimulus(2, 32'hABC, 1'b0, 1'b1);
      prev       = sclk[2];
      rises      = 0;
      bad_period = 0;
      last_rise  = -1;
      k          = 0;
      while (k < 400) begin
         @(negedge clk);
         k++;
         if (sclk[2] && !prev) begin
            if (last_rise >= 0 && (cyc - last_rise) != 8) bad_period++;
            last_rise = cyc;
            rises++;
         end
         prev = sclk[2];
         if (snt[2]) break;
         ce_slow = (k % 4 == 0);
         if (!rdy[2] && (k % 5 == 2)) begin
            wr[2]  = 1'b1;
            din[2] = 32'hFFF;
            kp[2]  = 1'b1;
         end else begin
            wr[2] = 1'b0;
         end
      end
      wr[2]   = 1'b0;
      ce_slow = 1'b0;
      checkOutput(10);
      check("slow_rising_edges", rises, 12);
      check("slow_bad_periods", bad_period, 0);
      repeat (4) @(negedge clk);
      check("slow_ready_after", rdy[2], 1);
      check("slow_no_extra_word", rec_n[2], rd[2]);

      $display("[TB] sweep WIDTH 2 and 32 over all modes");
      for (int c = 3; c < NCH; c++) begin
         for (int i = 0; i < 3; i++) begin
            applyStimulus(c, $urandom, (i == 1), 1'b1);
            checkOutput(2 * W_T[c] + 20);
         end
      end

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
